// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: data width, reset PC, PC step and the
// buffered fetch entry carried from instruction memory to decode.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle.
//   imem_re/imem_a/imem_rd             : instruction memory read port (1-cycle latency)
//   redirect_valid/redirect_pc         : control-flow redirect from execute
//   out_valid/out_ready/out_pc/out_instr : valid/ready stream to decode
// master = fetch unit side, slave = memory/execute/decode side.
interface ifetch_if;
    import riscv_pkg::*;

    logic            imem_re;
    logic [XLEN-1:0] imem_a;
    logic [XLEN-1:0] imem_rd;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output imem_re, imem_a, out_valid, out_pc, out_instr,
        input  imem_rd, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_re, imem_a, out_valid, out_pc, out_instr,
        output imem_rd, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_buf.sv
// Small FIFO of fetch entries between the memory return and decode.
//   i_push/i_push_data : write an entry at the tail
//   i_pop              : drop the head entry
//   i_flush            : empty the buffer (wins over push/pop)
//   o_count            : number of stored entries (registered)
//   o_head_c           : head entry, a mux of storage registers only
module fetch_buf
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output fetch_entry_t     o_head_c
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_count  = r_count;
    assign o_head_c = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch front end: issues sequential word fetches, buffers the
// returning instructions and presents them to decode with valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ifetch_if.master (imem read port, redirect input, decode stream)
module ifetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_inflight;
    logic [XLEN-1:0]  r_inflight_pc;

    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic [OCC_W-1:0] w_occ;
    logic             w_imem_re;

    // A redirect cancels the decode handshake of the same cycle
    assign w_flush = bus.redirect_valid;
    assign w_pop   = bus.out_valid & bus.out_ready & ~w_flush;
    assign w_push  = r_inflight & ~w_flush;

    // Slots that will be taken once this cycle's pop and the pending return settle
    assign w_occ = OCC_W'(w_count) - OCC_W'(w_pop) + OCC_W'(r_inflight);

    // rst_n gating keeps the read port quiet during reset and lets the first
    // request go out as soon as reset is released
    assign w_imem_re = rst_n & ~w_flush & (w_occ < OCC_W'(BUF_DEPTH));

    assign w_push_data.pc    = r_inflight_pc;
    assign w_push_data.instr = bus.imem_rd;

    // PC and outstanding-request tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (w_flush) begin
            r_fetch_pc <= align_pc(bus.redirect_pc);
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_imem_re;
            if (w_imem_re) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_count     (w_count),
        .o_head_c    (w_head)
    );

    assign bus.imem_re   = w_imem_re;
    assign bus.imem_a    = r_fetch_pc;
    assign bus.out_valid = (w_count != '0);
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = w_head.instr;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed timing checks plus a scoreboard of expected
// (pc, instr) deliveries popped by an independent monitor.
module tb_ifetch;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_A5A5;

    logic clk;
    logic rst_n;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp2_q [$];

    ifetch_if bus ();
    ifetch_if bus2 ();

    ifetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory models: mem[a] = a ^ key, one-cycle read, held otherwise
    logic [31:0] mem_rd  = '0;
    logic [31:0] mem2_rd = '0;
    always @(posedge clk) if (bus.imem_re)  mem_rd  <= bus.imem_a ^ MEM_KEY;
    always @(posedge clk) if (bus2.imem_re) mem2_rd <= bus2.imem_a ^ MEM_KEY;
    assign bus.imem_rd  = mem_rd;
    assign bus2.imem_rd = mem2_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the main DUT
    always @(negedge clk) begin
        if (rst_n && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("stream_unexpected", bus.out_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("stream_pc", bus.out_pc, e);
                check("stream_instr", bus.out_instr, e ^ MEM_KEY);
            end
        end
    end

    // Monitor for the wrap-around DUT: only the first deliveries are scored
    always @(negedge clk) begin
        if (rst_n && bus2.out_valid && bus2.out_ready && exp2_q.size() != 0) begin
            logic [31:0] e;
            e = exp2_q.pop_front();
            check("wrap_pc", bus2.out_pc, e);
            check("wrap_instr", bus2.out_instr, e ^ MEM_KEY);
        end
    end

    initial begin
        logic [31:0] rpc;
        rst_n               = 1'b0;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.out_ready      = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        exp2_q.push_back(32'hFFFF_FFF8);
        exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000);
        exp2_q.push_back(32'h0000_0004);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_re", 32'(bus.imem_re), 32'd0);
        check("rst_imem_a", bus.imem_a, 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_wrap_imem_a", bus2.imem_a, 32'hFFFF_FFF8);

        // cycle 0: first request right after release
        next_cycle(); rst_n = 1'b1; exp_restart(32'h0);
        @(negedge clk);
        check("c0_imem_re", 32'(bus.imem_re), 32'd1);
        check("c0_imem_a", bus.imem_a, 32'h0);
        check("c0_out_valid", 32'(bus.out_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check("c1_out_valid", 32'(bus.out_valid), 32'd0);
        check("c1_imem_a", bus.imem_a, 32'h4);
        for (int c = 2; c <= 9; c++) begin
            next_cycle(); @(negedge clk);
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_re", 32'(bus.imem_re), 32'd1);
            if (c == 2) check("c2_out_pc", bus.out_pc, 32'h0);
        end

        // decode stall: head frozen at pc 32, fetch throttled
        for (int c = 10; c <= 14; c++) begin
            next_cycle(); bus.out_ready = 1'b0; @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_pc", bus.out_pc, 32'd32);
            check("stall_instr", bus.out_instr, 32'd32 ^ MEM_KEY);
            check("stall_re", 32'(bus.imem_re), 32'd0);
        end
        for (int c = 15; c <= 20; c++) begin
            next_cycle(); bus.out_ready = 1'b1; @(negedge clk);
            check("resume_valid", 32'(bus.out_valid), 32'd1);
            if (c == 15) begin
                check("resume_re", 32'(bus.imem_re), 32'd1);
                check("resume_imem_a", bus.imem_a, 32'd40);
            end
        end

        // fill the buffer, then redirect with decode ready
        repeat (2) begin next_cycle(); bus.out_ready = 1'b0; end
        next_cycle();
        bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        exp_restart(32'h100);
        @(negedge clk);
        check("redir_re", 32'(bus.imem_re), 32'd0);
        next_cycle(); bus.redirect_valid = 1'b0; @(negedge clk);
        check("redir_n1_valid", 32'(bus.out_valid), 32'd0);
        check("redir_n1_imem_a", bus.imem_a, 32'h100);
        check("redir_n1_re", 32'(bus.imem_re), 32'd1);
        next_cycle(); @(negedge clk);
        check("redir_n2_valid", 32'(bus.out_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check("redir_n3_valid", 32'(bus.out_valid), 32'd1);
        check("redir_n3_pc", bus.out_pc, 32'h100);
        repeat (4) next_cycle();

        // back-to-back redirects: last one wins
        next_cycle(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; exp_restart(32'h200);
        @(negedge clk);
        check("b2b_first_re", 32'(bus.imem_re), 32'd0);
        next_cycle(); bus.redirect_pc = 32'h300; exp_restart(32'h300);
        @(negedge clk);
        check("b2b_second_re", 32'(bus.imem_re), 32'd0);
        check("b2b_second_valid", 32'(bus.out_valid), 32'd0);
        next_cycle(); bus.redirect_valid = 1'b0; @(negedge clk);
        check("b2b_imem_a", bus.imem_a, 32'h300);
        check("b2b_n1_valid", 32'(bus.out_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check("b2b_n2_valid", 32'(bus.out_valid), 32'd0);
        next_cycle(); @(negedge clk);
        check("b2b_n3_pc", bus.out_pc, 32'h300);
        repeat (4) next_cycle();

        // unaligned redirect target
        next_cycle(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103; exp_restart(32'h100);
        next_cycle(); bus.redirect_valid = 1'b0; @(negedge clk);
        check("unalign_imem_a", bus.imem_a, 32'h100);
        repeat (4) next_cycle();

        // random ready/redirect with a reset pulse in the middle
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                next_cycle(); rst_n = 1'b0; bus.redirect_valid = 1'b0; exp_q.delete();
                @(negedge clk);
                check("midrst_valid", 32'(bus.out_valid), 32'd0);
                check("midrst_re", 32'(bus.imem_re), 32'd0);
                check("midrst_pc", bus.out_pc, 32'h0);
                next_cycle(); @(negedge clk);
                check("midrst_valid2", 32'(bus.out_valid), 32'd0);
                next_cycle(); rst_n = 1'b1; exp_restart(32'h0);
                @(negedge clk);
                check("midrst_rel_valid", 32'(bus.out_valid), 32'd0);
                check("midrst_rel_imem_a", bus.imem_a, 32'h0);
                check("midrst_rel_re", 32'(bus.imem_re), 32'd1);
                next_cycle(); @(negedge clk);
                check("midrst_rel1_valid", 32'(bus.out_valid), 32'd0);
            end
            next_cycle();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rpc = 32'($urandom_range(0, 32'h0000_FFFF));
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = rpc;
                exp_restart(rpc & ~32'h3);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            @(negedge clk);
        end

        // drain with decode always ready: steady stream expected
        for (int c = 0; c < 10; c++) begin
            next_cycle(); bus.out_ready = 1'b1; bus.redirect_valid = 1'b0;
            @(negedge clk);
            if (c >= 6) check("drain_valid", 32'(bus.out_valid), 32'd1);
        end
        check("wrap_seq_done", 32'(exp2_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; fixed at 2 in this revision.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_re  output  1  instruction memory read enable.
REQ-006 imem_a  output  32  instruction memory byte address, word aligned.
REQ-007 imem_rd  input  32  instruction memory read data; valid the cycle after imem_re=1; held when imem_re=0.
REQ-008 redirect_valid  input  1  control-flow redirect (branch/jump/trap) from execute.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 out_valid  output  1  instruction available to decode.
REQ-011 out_ready  input  1  decode accepts this cycle.
REQ-012 out_pc  output  32  PC of the presented instruction.
REQ-013 out_instr  output  32  presented instruction word.

Function
REQ-014 fetch_pc register: imem_a SHALL equal fetch_pc every cycle.
REQ-015 pop = out_valid & out_ready; count = buffered entries; inflight = imem_re issued the previous cycle.
REQ-016 imem_re SHALL be 1 iff !redirect_valid and (count - pop + inflight) < 2.
REQ-017 When imem_re=1 and no redirect, fetch_pc SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 When inflight=1 and no redirect, {PC of that request, imem_rd} SHALL be written to the buffer tail.
REQ-019 Buffer SHALL be FIFO; out_valid = (count != 0); out_pc/out_instr SHALL come from the head entry, registered, no combinational path from imem_rd.
REQ-020 Latency: request in cycle N -> out_valid in N+2 if buffer empty.
REQ-021 Throughput: with out_ready held 1, one instruction per cycle sustained, no bubbles.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; buffer SHALL never overflow and never drop a response.
REQ-023 out_pc/out_instr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Redirect (any cycle): buffer flushed (count=0), in-flight response discarded, imem_re=0 that cycle, fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-025 After redirect in cycle N: request to the target in N+1, out_valid for target in N+3.
REQ-026 Redirect beats pop: decode handshake in the redirect cycle is ignored; out_valid SHALL be 0 in N+1.
REQ-027 Back-to-back redirects: last one wins; no instruction from an earlier target is delivered.
REQ-028 redirect_pc[1:0] SHALL be ignored.

Reset
REQ-029 While rst_n=0: fetch_pc=RESET_PC, count=0, inflight=0, imem_re=0, out_valid=0, out_pc=0, out_instr=0.
REQ-030 First imem_re=1 (imem_a=RESET_PC) in the first posedge cycle after rst_n deasserts.
REQ-031 Reset mid-operation SHALL discard buffered and in-flight instructions; no out_valid until the new fetch returns.

Structure
REQ-032 Shared package riscv_pkg SHALL hold XLEN=32, RESET_PC default, PC_STEP=4, and the fetch-entry type {pc[31:0], instr[31:0]}.
REQ-033 Buffer SHALL be sub-module fetch_buf (2-entry FIFO: push, pop, flush, count, head); pc/request control stays in ifetch.

Verification
REQ-034 Reset release, out_ready=1, imem returns mem[a]=a^32'hA5A5_A5A5 -> imem_a 0,4,8...; out_pc 0 at cycle 2, then 4,8,12 every cycle with matching instr.
REQ-035 out_ready=0 for 5 cycles mid-stream -> out_valid held, out_pc frozen, imem_re drops after buffer full; resumes with no gap, no duplicate, no skipped PC.
REQ-036 redirect_valid with redirect_pc=32'h0000_0100 while buffer holds 2 entries -> out_valid=0 next cycle, imem_a=32'h100 next cycle, out_pc=32'h100 three cycles after redirect, old PCs never appear.
REQ-037 Redirects to 32'h200 then 32'h300 on consecutive cycles -> only 32'h300 stream delivered; redirect_pc=32'h0000_0103 -> fetch at 32'h100.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-039 Random out_ready and random redirects vs. scoreboard model -> delivered (pc,instr) sequence exactly matches model; rst_n pulse mid-run -> restart at RESET_PC with no stale output.
